fetch_predict_stage: RTL and testbench

//  Pipeline stage 1 (instruction fetch). Owns the PC register and a direct-mapped

---
 rtl/fetch_predict_stage.sv | 154 +++++++++++++++
 tb/tb_fetch_predict_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fetch_predict_stage.sv
// Fetch stage: owns the PC and a direct-mapped BTB with 2-bit saturating counters.
// Lookup is purely combinational off the current PC; updates from EX land at the clock edge.

module fetch_predict_btb_entry #(
  parameter int ADDR_W = 10,
  parameter int TAG_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_taken,
  input  logic [ADDR_W-1:0] i_target,
  output logic              o_valid,
  output logic [TAG_W-1:0]  o_tag,
  output logic [ADDR_W-1:0] o_target,
  output logic [1:0]        o_ctr
);
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [1:0]        ctr;
  } ent_t;

  ent_t r_ent;
  ent_t w_nxt;
  logic w_match;

  assign w_match = r_ent.valid && (r_ent.tag == i_tag);

  always_comb begin
    w_nxt = r_ent;
    if (i_wr) begin
      if (w_match) begin
        if (i_taken) begin
          if (r_ent.ctr != 2'b11) w_nxt.ctr = r_ent.ctr + 2'b01;
          w_nxt.target = i_target;
        end else if (r_ent.ctr != 2'b00) begin
          w_nxt.ctr = r_ent.ctr - 2'b01;
        end
      end else if (i_taken) begin
        // Taken on a miss: claim the slot, starting weakly taken.
        w_nxt.valid  = 1'b1;
        w_nxt.tag    = i_tag;
        w_nxt.target = i_target;
        w_nxt.ctr    = 2'b10;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ent.valid  <= 1'b0;
      r_ent.tag    <= '0;
      r_ent.target <= '0;
      r_ent.ctr    <= 2'b01;
    end else begin
      r_ent <= w_nxt;
    end
  end

  assign o_valid  = r_ent.valid;
  assign o_tag    = r_ent.tag;
  assign o_target = r_ent.target;
  assign o_ctr    = r_ent.ctr;
endmodule

module fetch_predict_stage #(
  parameter int                ADDR_W   = 10,
  parameter int                IDX_W    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_redirect_en,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  input  logic              i_upd_en,
  input  logic [ADDR_W-1:0] i_upd_pc,
  input  logic              i_upd_taken,
  input  logic [ADDR_W-1:0] i_upd_target,
  output logic [ADDR_W-1:0] o_im_addr,
  output logic [ADDR_W-1:0] o_pc_4,
  output logic [ADDR_W-1:0] o_pc_guessed,
  output logic              o_pred_taken,
  output logic [31:0]       o_redirect_cnt
);
  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [ADDR_W-1:0]         r_pc;
  logic [31:0]               r_redirect_cnt;

  logic [N-1:0]              w_valid;
  logic [N-1:0][TAG_W-1:0]   w_tag;
  logic [N-1:0][ADDR_W-1:0]  w_target;
  logic [N-1:0][1:0]         w_ctr;

  logic [IDX_W-1:0]          w_idx;
  logic [IDX_W-1:0]          w_upd_idx;
  logic                      w_hit;
  logic [ADDR_W-1:0]         w_pc_4;
  logic [ADDR_W-1:0]         w_pc_guessed;
  logic                      w_pred_taken;

  assign w_upd_idx = i_upd_pc[IDX_W-1:0];

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_btb
      fetch_predict_btb_entry #(
        .ADDR_W (ADDR_W),
        .TAG_W  (TAG_W)
      ) u_ent (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_wr     (i_upd_en && (w_upd_idx == IDX_W'(g))),
        .i_tag    (i_upd_pc[ADDR_W-1:IDX_W]),
        .i_taken  (i_upd_taken),
        .i_target (i_upd_target),
        .o_valid  (w_valid[g]),
        .o_tag    (w_tag[g]),
        .o_target (w_target[g]),
        .o_ctr    (w_ctr[g])
      );
    end
  endgenerate

  // Lookup reads the pre-edge BTB contents, so an update to the slot being fetched
  // only becomes visible on the next cycle.
  assign w_idx        = r_pc[IDX_W-1:0];
  assign w_hit        = w_valid[w_idx] && (w_tag[w_idx] == r_pc[ADDR_W-1:IDX_W]);
  assign w_pred_taken = w_hit && w_ctr[w_idx][1];
  assign w_pc_4       = r_pc + ADDR_W'(1);
  assign w_pc_guessed = w_pred_taken ? w_target[w_idx] : w_pc_4;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc           <= RESET_PC;
      r_redirect_cnt <= '0;
    end else begin
      if (i_redirect_en)  r_pc <= i_redirect_pc;
      else if (i_en)      r_pc <= w_pc_guessed;
      if (i_redirect_en)  r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end

  assign o_im_addr      = r_pc;
  assign o_pc_4         = w_pc_4;
  assign o_pc_guessed   = w_pc_guessed;
  assign o_pred_taken   = w_pred_taken;
  assign o_redirect_cnt = r_redirect_cnt;
endmodule

// File: tb/tb_fetch_predict_stage.sv
// Directed per-cycle vector table for fetch_predict_stage plus an async reset sequence.
module tb_fetch_predict_stage;
  localparam int AW = 10;

  logic          clk, rst_n, en, rd_en, up_en, up_t;
  logic [AW-1:0] rd_pc, up_pc, up_tgt;
  logic [AW-1:0] im_addr, pc_4, pc_guessed;
  logic          pred_taken;
  logic [31:0]   redirect_cnt;

  int checks = 0;
  int failures = 0;

  fetch_predict_stage #(.ADDR_W(AW), .IDX_W(4), .RESET_PC('0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .i_redirect_en(rd_en), .i_redirect_pc(rd_pc),
    .i_upd_en(up_en), .i_upd_pc(up_pc), .i_upd_taken(up_t), .i_upd_target(up_tgt),
    .o_im_addr(im_addr), .o_pc_4(pc_4), .o_pc_guessed(pc_guessed),
    .o_pred_taken(pred_taken), .o_redirect_cnt(redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          en, rd;
    logic [AW-1:0] rdpc;
    logic          up;
    logic [AW-1:0] uppc;
    logic          upt;
    logic [AW-1:0] uptgt;
    logic [AW-1:0] e_im, e_g;
    logic          e_pt;
    logic [31:0]   e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic e, input logic r, input int rp, input logic u,
                     input int upc, input logic ut, input int utg,
                     input int eim, input int eg, input logic ept, input int ecnt);
    vec_t v;
    v.en = e; v.rd = r; v.rdpc = AW'(rp); v.up = u; v.uppc = AW'(upc);
    v.upt = ut; v.uptgt = AW'(utg); v.e_im = AW'(eim); v.e_g = AW'(eg);
    v.e_pt = ept; v.e_cnt = 32'(ecnt);
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [AW-1:0] eim, input logic [AW-1:0] eg,
                         input logic ept, input logic [31:0] ecnt);
    logic [AW-1:0] e4;
    e4 = eim + AW'(1);
    chk({tag, ".im_addr"}, 32'(im_addr), 32'(eim));
    chk({tag, ".pc_4"}, 32'(pc_4), 32'(e4));
    chk({tag, ".pc_guessed"}, 32'(pc_guessed), 32'(eg));
    chk({tag, ".pred_taken"}, 32'(pred_taken), 32'(ept));
    chk({tag, ".redirect_cnt"}, redirect_cnt, ecnt);
  endtask

  task automatic idle_inputs();
    en = 1'b0; rd_en = 1'b0; rd_pc = '0; up_en = 1'b0; up_pc = '0; up_t = 1'b0; up_tgt = '0;
  endtask

  initial begin
    //   en rd rdpc  up upc   t  tgt    im     guess  pt cnt
    add(1, 0, 0,     0, 0,    0, 0,     'h000, 'h001, 0, 0);
    add(1, 0, 0,     1, 5,    1, 'h20,  'h001, 'h002, 0, 0);
    add(1, 0, 0,     0, 0,    0, 0,     'h002, 'h003, 0, 0);
    add(1, 0, 0,     0, 0,    0, 0,     'h003, 'h004, 0, 0);
    add(1, 0, 0,     0, 0,    0, 0,     'h004, 'h005, 0, 0);
    add(1, 0, 0,     0, 0,    0, 0,     'h005, 'h020, 1, 0);
    add(1, 0, 0,     1, 5,    0, 0,     'h020, 'h021, 0, 0);  // ctr 2->1
    add(1, 0, 0,     1, 5,    0, 0,     'h021, 'h022, 0, 0);  // ctr 1->0
    add(1, 0, 0,     1, 5,    1, 'h20,  'h022, 'h023, 0, 0);  // ctr 0->1
    add(1, 1, 5,     0, 0,    0, 0,     'h023, 'h024, 0, 0);
    add(1, 0, 0,     1, 5,    0, 0,     'h005, 'h006, 0, 1);  // ctr 1->0
    add(1, 0, 0,     1, 5,    0, 0,     'h006, 'h007, 0, 1);  // holds 0
    add(1, 0, 0,     1, 5,    1, 'h30,  'h007, 'h008, 0, 1);  // ctr 0->1
    add(1, 1, 5,     0, 0,    0, 0,     'h008, 'h009, 0, 1);
    add(1, 0, 0,     1, 5,    1, 'h30,  'h005, 'h006, 0, 2);  // old ctr seen; ctr 1->2
    add(1, 1, 'h15,  0, 0,    0, 0,     'h006, 'h007, 0, 2);
    add(1, 0, 0,     1, 'h15, 0, 0,     'h015, 'h016, 0, 3);  // alias miss, NT: no change
    add(1, 1, 5,     0, 0,    0, 0,     'h016, 'h017, 0, 3);
    add(0, 0, 0,     0, 0,    0, 0,     'h005, 'h030, 1, 4);
    add(0, 0, 0,     0, 0,    0, 0,     'h005, 'h030, 1, 4);
    add(0, 1, 'h40,  0, 0,    0, 0,     'h005, 'h030, 1, 4);
    add(0, 0, 0,     0, 0,    0, 0,     'h040, 'h041, 0, 5);
    add(1, 1, 'h3FF, 0, 0,    0, 0,     'h040, 'h041, 0, 5);
    add(1, 0, 0,     0, 0,    0, 0,     'h3FF, 'h000, 0, 6);
    add(1, 0, 0,     1, 'h3FF,1, 'h10,  'h000, 'h001, 0, 6);
    add(1, 1, 'h3FF, 0, 0,    0, 0,     'h001, 'h002, 0, 6);
    add(1, 0, 0,     0, 0,    0, 0,     'h3FF, 'h010, 1, 7);
    add(1, 1, 'h2F,  1, 'h2F, 1, 'h55,  'h010, 'h011, 0, 7);  // redirect + replace same edge
    add(1, 0, 0,     0, 0,    0, 0,     'h02F, 'h055, 1, 8);
    add(1, 0, 0,     0, 0,    0, 0,     'h055, 'h056, 0, 8);

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_all("reset", 'h000, 'h001, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      en = tbl[k].en; rd_en = tbl[k].rd; rd_pc = tbl[k].rdpc;
      up_en = tbl[k].up; up_pc = tbl[k].uppc; up_t = tbl[k].upt; up_tgt = tbl[k].uptgt;
      #1 chk_all($sformatf("vec%0d", k), tbl[k].e_im, tbl[k].e_g, tbl[k].e_pt, tbl[k].e_cnt);
    end

    // Mid-run async reset: PC and counter clear without waiting for an edge.
    @(negedge clk);
    idle_inputs();
    en = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst.im_addr", 32'(im_addr), 32'h0);
    chk("async_rst.redirect_cnt", redirect_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    rd_en = 1'b1; rd_pc = AW'('h2F);
    @(negedge clk);
    rd_en = 1'b0;
    #1 chk_all("post_rst_2F", 'h02F, 'h030, 1'b0, 32'd1);
    @(negedge clk);
    rd_en = 1'b1; rd_pc = AW'(5);
    @(negedge clk);
    rd_en = 1'b0;
    #1 chk_all("post_rst_5", 'h005, 'h006, 1'b0, 32'd2);

    // Stall for several cycles holds the PC.
    repeat (4) @(negedge clk);
    #1 chk("stall_hold.im_addr", 32'(im_addr), 32'h5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
